// File: rtl/opb_cfg_seq_pkg.sv
// Shared constants for the OPB configuration-write sequencer: FSM encodings,
// the table end marker and the full-word byte enable.
package opb_cfg_seq_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_REQ  = 3'd2;
  localparam logic [2:0] ST_XFER = 3'd3;
  localparam logic [2:0] ST_NEXT = 3'd4;
  localparam logic [2:0] ST_FIN  = 3'd5;
  localparam logic [2:0] ST_ERR  = 3'd6;

  localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;
  localparam logic [3:0]  BE_ALL     = 4'hF;

endpackage

// File: rtl/opb_xfer_watchdog.sv
// Counts consecutive enabled cycles; expired is high during the C_WDOG_CYCLES-th one,
// so the owner can leave on that same edge.
module opb_xfer_watchdog #(
  parameter int C_WDOG_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(C_WDOG_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == CW'(C_WDOG_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/opb_cfg_write_sequencer.sv
// OPB write-only master that replays a configuration table into OPB slaves after start,
// handling arbitration, retry, error acknowledge, bus timeout and a per-transfer watchdog.
module opb_cfg_write_sequencer
  import opb_cfg_seq_pkg::*;
#(
  parameter int C_OPB_AWIDTH  = 32,
  parameter int C_OPB_DWIDTH  = 32,
  parameter int C_NUM_ENTRIES = 16,
  parameter int C_MAX_RETRY   = 4,
  parameter int C_WDOG_CYCLES = 16,
  parameter int IDXW          = $clog2(C_NUM_ENTRIES)
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [IDXW-1:0]         err_index,
  output logic [IDXW-1:0]         tbl_idx,
  input  logic [0:C_OPB_AWIDTH-1] tbl_addr,
  input  logic [0:C_OPB_DWIDTH-1] tbl_data,
  output logic                    M_request,
  input  logic                    OPB_MGrant,
  output logic                    M_select,
  output logic                    M_busLock,
  output logic                    M_seqAddr,
  output logic                    M_RNW,
  output logic [0:3]              M_BE,
  output logic [0:C_OPB_AWIDTH-1] M_ABus,
  output logic [0:C_OPB_DWIDTH-1] M_DBus,
  input  logic                    OPB_xferAck,
  input  logic                    OPB_errAck,
  input  logic                    OPB_retry,
  input  logic                    OPB_timeout,
  output logic [2:0]              dbg_state
);

  localparam int RW = $clog2(C_MAX_RETRY + 1);

  logic [2:0]              state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [IDXW-1:0]         err_idx_q, err_idx_d;
  logic [RW-1:0]           retry_q, retry_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    request_q, request_d;
  logic                    select_q, select_d;
  logic [0:C_OPB_AWIDTH-1] addr_q, addr_d;
  logic [0:C_OPB_DWIDTH-1] data_q, data_d;
  logic                    wd_expired;

  opb_xfer_watchdog #(.C_WDOG_CYCLES(C_WDOG_CYCLES)) u_wdog (
    .clk     (OPB_Clk),
    .rst     (OPB_Rst),
    .clr     (state_q != ST_XFER),
    .en      (state_q == ST_XFER),
    .expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_idx_d = err_idx_q;
    retry_d   = retry_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    request_d = request_q;
    select_d  = select_q;
    addr_d    = addr_q;
    data_d    = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          retry_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        addr_d = tbl_addr;
        data_d = tbl_data;
        if (tbl_addr == END_MARKER) begin
          state_d = ST_FIN;
        end else begin
          request_d = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (OPB_MGrant) begin
          request_d = 1'b0;
          select_d  = 1'b1;
          state_d   = ST_XFER;
        end
      end
      ST_XFER: begin
        // Error responses beat a same-cycle ack; ack beats retry; watchdog is the fallback.
        if (OPB_errAck || OPB_timeout) begin
          select_d = 1'b0;
          state_d  = ST_ERR;
        end else if (OPB_xferAck) begin
          select_d = 1'b0;
          state_d  = ST_NEXT;
        end else if (OPB_retry) begin
          select_d = 1'b0;
          retry_d  = retry_q + RW'(1);
          if (retry_d == RW'(C_MAX_RETRY)) begin
            state_d = ST_ERR;
          end else begin
            request_d = 1'b1;
            state_d   = ST_REQ;
          end
        end else if (wd_expired) begin
          select_d = 1'b0;
          state_d  = ST_ERR;
        end
      end
      ST_NEXT: begin
        retry_d = '0;
        if (idx_q == IDXW'(C_NUM_ENTRIES - 1)) begin
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = ST_LOAD;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        error_d   = 1'b1;
        err_idx_d = idx_q;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      err_idx_q <= '0;
      retry_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      request_q <= 1'b0;
      select_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_idx_q <= err_idx_d;
      retry_q   <= retry_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      request_q <= request_d;
      select_q  <= select_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  // Address, data and byte enables are gated by select so this master ORs zero onto the bus when idle.
  assign M_ABus    = select_q ? addr_q : '0;
  assign M_DBus    = select_q ? data_q : '0;
  assign M_BE      = select_q ? BE_ALL : 4'h0;
  assign M_select  = select_q;
  assign M_request = request_q;
  assign M_RNW     = 1'b0;
  assign M_busLock = 1'b0;
  assign M_seqAddr = 1'b0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = err_idx_q;
  assign tbl_idx   = idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_opb_cfg_write_sequencer.sv
// Bench for opb_cfg_write_sequencer: a behavioural OPB arbiter/slave answers each select
// phase, and every acknowledged write is checked against an expected-write queue.
module tb_opb_cfg_write_sequencer;

  localparam logic [31:0] END_M = 32'hFFFF_FFFF;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [3:0]  err_index, tbl_idx;
  logic [0:31] tbl_addr, tbl_data;
  logic        M_request, M_select, M_busLock, M_seqAddr, M_RNW;
  logic        OPB_MGrant = 1'b0;
  logic        OPB_xferAck = 1'b0, OPB_errAck = 1'b0, OPB_retry = 1'b0, OPB_timeout = 1'b0;
  logic [0:3]  M_BE;
  logic [0:31] M_ABus, M_DBus;
  logic [2:0]  dbg_state;

  opb_cfg_write_sequencer dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .start(start), .busy(busy), .done(done),
    .error(error), .err_index(err_index), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .M_request(M_request), .OPB_MGrant(OPB_MGrant),
    .M_select(M_select), .M_busLock(M_busLock), .M_seqAddr(M_seqAddr), .M_RNW(M_RNW),
    .M_BE(M_BE), .M_ABus(M_ABus), .M_DBus(M_DBus), .OPB_xferAck(OPB_xferAck),
    .OPB_errAck(OPB_errAck), .OPB_retry(OPB_retry), .OPB_timeout(OPB_timeout),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 OPB_Clk = ~OPB_Clk;

  // table and slave behaviour knobs
  logic [31:0] t_addr[16];
  logic [31:0] t_data[16];
  assign tbl_addr = t_addr[tbl_idx];
  assign tbl_data = t_data[tbl_idx];

  int grant_delay = 0, ack_delay = 0, retry_left = 0, err_at = -1, to_cycle = -1;
  bit never_ack = 1'b0;
  int req_cyc = 0, sel_cyc = 0, phase_cnt = 0, last_len = 0, write_cnt = 0, orbus_bad = 0;

  // scoreboard
  logic [68:0] exp_q[$];
  int total = 0, bad = 0;

  // Arbiter/slave model: responses are decided at the falling edge for the cycle the DUT samples next.
  always @(negedge OPB_Clk) begin
    int cur;
    logic [68:0] e;
    OPB_MGrant = 1'b0; OPB_xferAck = 1'b0; OPB_errAck = 1'b0;
    OPB_retry = 1'b0;  OPB_timeout = 1'b0;
    if (M_request) begin
      if (req_cyc >= grant_delay) OPB_MGrant = 1'b1;
      req_cyc++;
    end else begin
      req_cyc = 0;
    end
    if (M_select) begin
      cur = sel_cyc;
      sel_cyc++;
      if (cur == 0) phase_cnt++;
      if (never_ack) begin
        if (cur == to_cycle) OPB_timeout = 1'b1;
      end else if (cur >= ack_delay) begin
        if (err_at >= 0 && int'(tbl_idx) == err_at) begin
          OPB_errAck = 1'b1;
        end else if (retry_left > 0) begin
          OPB_retry = 1'b1;
          retry_left--;
        end else begin
          OPB_xferAck = 1'b1;
          write_cnt++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL write: unexpected write addr=%h data=%h, expected none", M_ABus, M_DBus);
          end else begin
            e = exp_q.pop_front();
            if ({M_ABus, M_DBus, M_BE, M_RNW} !== e)
              $display("FAIL write: got addr=%h data=%h be=%h rnw=%b, expected addr=%h data=%h be=%h rnw=%b",
                       M_ABus, M_DBus, M_BE, M_RNW, e[68:37], e[36:5], e[4:1], e[0]);
            if ({M_ABus, M_DBus, M_BE, M_RNW} !== e) bad++;
          end
        end
      end
    end else begin
      if (sel_cyc != 0) last_len = sel_cyc;
      sel_cyc = 0;
      if (M_ABus != 0 || M_DBus != 0 || M_BE != 0) orbus_bad++;
    end
  end

  // driver tasks
  task automatic fill_table(input int n);
    for (int i = 0; i < 16; i++) begin
      t_addr[i] = (i < n) ? (32'h0100_0000 | ($urandom & 32'h00FF_FFFC)) : END_M;
      t_data[i] = $urandom;
    end
  endtask

  task automatic push_exp(input int k);
    for (int i = 0; i < k; i++) exp_q.push_back({t_addr[i], t_data[i], 4'hF, 1'b0});
  endtask

  task automatic set_slave(input int gd, input int ad, input int rl, input int ea,
                           input bit na, input int tc);
    grant_delay = gd; ack_delay = ad; retry_left = rl; err_at = ea; never_ack = na; to_cycle = tc;
    phase_cnt = 0; write_cnt = 0;
  endtask

  task automatic pulse_start;
    @(negedge OPB_Clk); start = 1'b1;
    @(negedge OPB_Clk); start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge OPB_Clk);
      n++;
    end
    total++;
    if (!(done || error)) begin
      bad++;
      $display("FAIL wait_end: done=%b error=%b after %0d cycles, expected done or error", done, error, budget);
    end
  endtask

  // tests
  task automatic test_reset;
    repeat (3) @(negedge OPB_Clk);
    total++;
    if ({busy, done, error, M_request, M_select, M_RNW, M_busLock, M_seqAddr} !== 8'h00) begin
      bad++;
      $display("FAIL reset_flags: got %b, expected 00000000",
               {busy, done, error, M_request, M_select, M_RNW, M_busLock, M_seqAddr});
    end
    total++;
    if ({M_ABus, M_DBus, M_BE} !== 68'h0) begin
      bad++; $display("FAIL reset_bus: got %h %h %h, expected all zero", M_ABus, M_DBus, M_BE);
    end
    total++;
    if ({tbl_idx, err_index, dbg_state} !== 11'h0) begin
      bad++; $display("FAIL reset_idx: tbl_idx=%0d err_index=%0d state=%0d, expected 0", tbl_idx, err_index, dbg_state);
    end
    OPB_Rst = 1'b0;
  endtask

  task automatic test_basic;
    fill_table(2);
    t_addr[0] = 32'h0106_0600; t_data[0] = 32'hA5A5_0001;
    t_addr[1] = 32'h0106_0700; t_data[1] = 32'h0000_00FF;
    push_exp(2);
    set_slave(0, 0, 0, -1, 1'b0, -1);
    pulse_start();
    total++;
    if ({busy, done, error} !== 3'b100) begin
      bad++; $display("FAIL basic_start: busy/done/error=%b, expected 100", {busy, done, error});
    end
    wait_end(200);
    total++;
    if ({busy, done, error} !== 3'b010) begin
      bad++; $display("FAIL basic_end: busy/done/error=%b, expected 010", {busy, done, error});
    end
    total++;
    if (write_cnt !== 2 || exp_q.size() !== 0) begin
      bad++; $display("FAIL basic_count: writes=%0d left=%0d, expected 2 and 0", write_cnt, exp_q.size());
    end
  endtask

  task automatic test_full_table;
    fill_table(16);
    push_exp(16);
    set_slave(1, 1, 0, -1, 1'b0, -1);
    pulse_start();
    repeat (10) @(negedge OPB_Clk);
    start = 1'b1;
    @(negedge OPB_Clk);
    start = 1'b0;
    wait_end(1000);
    total++;
    if (write_cnt !== 16 || exp_q.size() !== 0) begin
      bad++; $display("FAIL full_count: writes=%0d left=%0d, expected 16 and 0", write_cnt, exp_q.size());
    end
    total++;
    if ({done, error, tbl_idx} !== {2'b10, 4'd15}) begin
      bad++; $display("FAIL full_end: done=%b error=%b tbl_idx=%0d, expected 1 0 15", done, error, tbl_idx);
    end
  endtask

  task automatic test_err_ack;
    fill_table(4);
    push_exp(2);
    set_slave(0, 2, 0, 2, 1'b0, -1);
    pulse_start();
    wait_end(300);
    repeat (3) @(negedge OPB_Clk);
    total++;
    if ({done, error, err_index, M_select, busy} !== {2'b01, 4'd2, 2'b00}) begin
      bad++; $display("FAIL err_ack: done=%b error=%b err_index=%0d sel=%b busy=%b, expected 0 1 2 0 0",
                      done, error, err_index, M_select, busy);
    end
    total++;
    if (write_cnt !== 2 || exp_q.size() !== 0) begin
      bad++; $display("FAIL err_ack_count: writes=%0d left=%0d, expected 2 and 0", write_cnt, exp_q.size());
    end
  endtask

  task automatic test_retry;
    fill_table(1);
    push_exp(1);
    set_slave(0, 0, 3, -1, 1'b0, -1);
    pulse_start();
    total++;
    if ({done, error, busy} !== 3'b001) begin
      bad++; $display("FAIL restart_clear: done/error/busy=%b, expected 001", {done, error, busy});
    end
    wait_end(300);
    total++;
    if ({done, error} !== 2'b10 || phase_cnt !== 4 || exp_q.size() !== 0) begin
      bad++; $display("FAIL retry3: done=%b error=%b phases=%0d left=%0d, expected 1 0 4 0",
                      done, error, phase_cnt, exp_q.size());
    end
    set_slave(0, 0, 4, -1, 1'b0, -1);
    pulse_start();
    wait_end(300);
    total++;
    if ({done, error, err_index} !== {2'b01, 4'd0} || phase_cnt !== 4 || write_cnt !== 0) begin
      bad++; $display("FAIL retry4: done=%b error=%b err_index=%0d phases=%0d writes=%0d, expected 0 1 0 4 0",
                      done, error, err_index, phase_cnt, write_cnt);
    end
  endtask

  task automatic test_watchdog;
    fill_table(3);
    set_slave(0, 0, 0, -1, 1'b1, -1);
    pulse_start();
    wait_end(300);
    @(negedge OPB_Clk);
    total++;
    if ({error, err_index} !== {1'b1, 4'd0} || last_len !== 16) begin
      bad++; $display("FAIL watchdog: error=%b err_index=%0d xfer_cycles=%0d, expected 1 0 16", error, err_index, last_len);
    end
    set_slave(0, 0, 0, -1, 1'b1, 3);
    pulse_start();
    wait_end(300);
    @(negedge OPB_Clk);
    total++;
    if ({error, done} !== 2'b10 || last_len !== 4) begin
      bad++; $display("FAIL timeout: error=%b done=%b xfer_cycles=%0d, expected 1 0 4", error, done, last_len);
    end
  endtask

  task automatic test_async_reset;
    int n = 0;
    fill_table(3);
    set_slave(0, 0, 0, -1, 1'b1, -1);
    pulse_start();
    while (!M_select && n < 50) begin
      @(negedge OPB_Clk);
      n++;
    end
    total++;
    if (M_select !== 1'b1) begin
      bad++; $display("FAIL rst_setup: M_select=%b after %0d cycles, expected 1", M_select, n);
    end
    #3 OPB_Rst = 1'b1;
    #1;
    total++;
    if ({M_select, M_request, busy, dbg_state} !== 6'h0) begin
      bad++; $display("FAIL async_rst: sel=%b req=%b busy=%b state=%0d, expected all 0",
                      M_select, M_request, busy, dbg_state);
    end
    @(negedge OPB_Clk);
    OPB_Rst = 1'b0;
    fill_table(3);
    push_exp(3);
    set_slave(0, 0, 0, -1, 1'b0, -1);
    pulse_start();
    wait_end(300);
    total++;
    if (done !== 1'b1 || write_cnt !== 3 || exp_q.size() !== 0) begin
      bad++; $display("FAIL rst_replay: done=%b writes=%0d left=%0d, expected 1 3 0", done, write_cnt, exp_q.size());
    end
  endtask

  task automatic test_random;
    int n;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 8);
      fill_table(n);
      push_exp(n);
      set_slave($urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 3), -1, 1'b0, -1);
      pulse_start();
      wait_end(1000);
      total++;
      if ({done, error} !== 2'b10 || write_cnt !== n || exp_q.size() !== 0) begin
        bad++; $display("FAIL random%0d: done=%b error=%b writes=%0d left=%0d, expected 1 0 %0d 0",
                        r, done, error, write_cnt, exp_q.size(), n);
      end
    end
  endtask

  task automatic test_orbus;
    total++;
    if (orbus_bad !== 0) begin
      bad++; $display("FAIL orbus: %0d idle cycles drove nonzero bus, expected 0", orbus_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_table();
    test_err_ack();
    test_retry();
    test_watchdog();
    test_async_reset();
    test_random();
    test_orbus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
